// File: rtl/pulse_train_generator.sv
// Emits num_pulses clean pulses (programmable high/low widths) per rising edge of start.
// Optional abort input when PULSE_TRAIN_ABORT_EN is defined; default build has no abort.
module pulse_train_generator #(
    parameter int CNT_W   = 4,
    parameter int WIDTH_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_pulses,
    input  logic [WIDTH_W-1:0] high_cycles,
    input  logic [WIDTH_W-1:0] low_cycles,
`ifdef PULSE_TRAIN_ABORT_EN
    input  logic               abort,
`endif
    output logic               pulse_out,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pulses_sent
);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               start_q;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [WIDTH_W-1:0] high_q, high_d, low_q, low_d;
    logic [WIDTH_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic               pulse_q, pulse_d, busy_q, busy_d, done_q, done_d;
    logic               accept, abort_hit;

    // Timer counts down to zero, so a phase of max(x,1) cycles loads max(x,1)-1.
    function automatic logic [WIDTH_W-1:0] phase_load(input logic [WIDTH_W-1:0] x);
        return (x == '0) ? '0 : x - WIDTH_W'(1);
    endfunction

`ifdef PULSE_TRAIN_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign accept = start & ~start_q & (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        high_d  = high_q;
        low_d   = low_q;
        timer_d = timer_q;
        sent_d  = sent_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    num_d  = num_pulses;
                    high_d = high_cycles;
                    low_d  = low_cycles;
                    sent_d = '0;
                    if (num_pulses != '0) begin
                        state_d = S_HIGH;
                        timer_d = phase_load(high_cycles);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_HIGH: begin
                // A truncated high phase is not counted as a sent pulse.
                if (abort_hit) begin
                    state_d = S_DONE;
                end else if (timer_q == '0) begin
                    state_d = S_LOW;
                    timer_d = phase_load(low_q);
                    sent_d  = sent_q + CNT_W'(1);
                end else begin
                    timer_d = timer_q - WIDTH_W'(1);
                end
            end
            S_LOW: begin
                if (abort_hit) begin
                    state_d = S_DONE;
                end else if (timer_q == '0) begin
                    if (sent_q < num_q) begin
                        state_d = S_HIGH;
                        timer_d = phase_load(high_q);
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    timer_d = timer_q - WIDTH_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        pulse_d = (state_d == S_HIGH);
        busy_d  = (state_d == S_HIGH) || (state_d == S_LOW);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            num_q   <= '0;
            high_q  <= '0;
            low_q   <= '0;
            timer_q <= '0;
            sent_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            num_q   <= num_d;
            high_q  <= high_d;
            low_q   <= low_d;
            timer_q <= timer_d;
            sent_q  <= sent_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pulse_out   = pulse_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulses_sent = sent_q;

endmodule
